alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised multi-cycle ALU, successor to the 32-bit single-cycle alu32. Adds iterative
//  multiply/divide and a valid/ready handshake on both sides so the CPU datapath or a
//  calculator front-end can stall on long ops. Single-cycle ops still complete with
//  1-cycle latency. All outputs are registered.
// PARAMETERS
//  WIDTH   32             operand/result width; >=8, power of 2
//  SHW     $clog2(WIDTH)  shift-amount width (derived, do not override)
// PORTS
//  clk         in   1      clock, rising edge
//  reset_n     in   1      asynchronous active-low reset
//  in_valid    in   1      srca/srcb/alucontrol/shamt valid
//  in_ready    out  1      block accepts a new op this cycle
//  srca        in   WIDTH  operand A
//  srcb        in   WIDTH  operand B
//  alucontrol  in   4      opcode (table below)
//  shamt       in   SHW    shift amount for SLL/SRL/SRA
//  out_valid   out  1      aluout/zero/err valid
//  out_ready   in   1      consumer takes result this cycle
//  aluout      out  WIDTH  result
//  zero        out  1      aluout == 0
//  err         out  1      illegal/unsupported opcode
// BEHAVIOUR
//  - Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SRA,
//    0111 SLT (signed), 1000 SLTU, 1001 SUB, 1010 MUL (low WIDTH), 1011 MULHU (high WIDTH),
//    1100 DIVU, 1101 REMU; 1110/1111 illegal. ADD/SUB wrap mod 2^WIDTH; SLT/SLTU give 0 or 1.
//  - Reset (async, any state incl. mid-MUL/DIV): state=IDLE, out_valid=0, aluout=0, zero=0,
//    err=0, in_ready=1 after reset release; in-flight op discarded.
//  - Accept: in_valid && in_ready at a rising edge. in_ready = (state==IDLE) &&
//    (!out_valid || out_ready); back-to-back single-cycle ops sustain 1 op/cycle.
//  - FSM: IDLE -> DONE on accept of ops 0000-1001 or illegal (result computed same edge);
//    IDLE -> MUL (1010/1011) or DIV (1100/1101); MUL/DIV run WIDTH cycles, counter 0..WIDTH-1,
//    then -> DONE. DONE: out_valid=1; leave on out_ready, to IDLE, or directly to
//    MUL/DIV/DONE if a new op is accepted the same edge.
//  - Latency: single-cycle ops out_valid 1 cycle after accept; MUL/DIV WIDTH+1 cycles.
//  - MUL: shift-add on unsigned operands, 2*WIDTH accumulator; MUL returns low half,
//    MULHU high half.
//  - DIV: restoring, 1 quotient bit/cycle, unsigned. srcb==0: DIVU -> all ones,
//    REMU -> srca (no err). Operands latched at accept; inputs may change afterwards.
//  - Illegal opcode: aluout=0, zero=1, err=1, 1-cycle latency.
//  - Output hold: while out_valid && !out_ready, aluout/zero/err stay stable.
//  - in_ready=0 during MUL/DIV; in_valid ignored then (no queueing).
// CONFIGURATION
//  ALU_SEQ_DIV_EN defined: DIVU/REMU implemented as above.
//  Not defined: divider logic removed; 1100/1101 treated as illegal (err=1, aluout=0,
//  1-cycle latency); MUL path unchanged.
// TESTING (WIDTH=32 unless noted)
//  ADD 0x00000234+0x00000EFF, out_ready=1 -> aluout=0x00001133, zero=0, out_valid 1 cycle later
//  SUB 5-5 then SRA 0x80000000 shamt=4 back-to-back -> 0x0 zero=1, then 0xF8000000; in_ready stays 1
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles; MUL same -> 0x00000001; in_ready=0 meanwhile
//  DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234 (DIV_EN set)
//  out_ready=0 for 5 cycles after ADD 1+1 -> aluout=2 held, in_ready=0; release -> accepted next op
//  reset_n low at cycle 10 of a MUL -> out_valid=0, aluout=0 immediately; opcode 1111 -> err=1, zero=1

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: parametrised multi-cycle ALU with valid/ready handshakes on input and output.
// Single-cycle ops finish in one cycle. MUL/MULHU use an iterative shift-add unit.
// DIVU/REMU use a restoring divider that is built only when ALU_SEQ_DIV_EN is defined;
// when it is undefined, those two opcodes are reported as illegal.
module alu_seq #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alucontrol,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             err
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SRA   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi, lo}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand or divisor
  logic [3:0]         op_q, op_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               busy;
  logic               accept;
  logic               op_is_mul;
  logic               op_is_div;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_err;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] iter_next;
  logic [WIDTH-1:0]   iter_res;
  logic               res_hi;
  logic               last_step;

  assign busy      = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign in_ready  = !busy && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign op_is_mul = (alucontrol == OP_MUL) || (alucontrol == OP_MULHU);

  assign out_valid = out_valid_q;
  assign aluout    = aluout_q;
  assign zero      = zero_q;
  assign err       = err_q;

  // Single-cycle result and illegal-opcode decode.
  always_comb begin
    sc_res = '0;
    sc_err = 1'b0;
    case (alucontrol)
      OP_AND:  sc_res = srca & srcb;
      OP_OR:   sc_res = srca | srcb;
      OP_ADD:  sc_res = srca + srcb;
      OP_XOR:  sc_res = srca ^ srcb;
      OP_SLL:  sc_res = srca << shamt;
      OP_SRL:  sc_res = srca >> shamt;
      OP_SRA:  sc_res = WIDTH'($signed(srca) >>> shamt);
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      OP_SUB:  sc_res = srca - srcb;
      default: sc_err = 1'b1;
    endcase
  end

  // One shift-add multiply step: add the multiplicand when the low bit is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] div_next;

  // One restoring divide step; a zero divisor naturally yields all-ones quotient and rem = dividend.
  always_comb begin
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
  end

  assign iter_next = (state_q == ST_DIV) ? div_next : mul_next;
  assign op_is_div = (alucontrol == OP_DIVU) || (alucontrol == OP_REMU);
`else
  assign iter_next = mul_next;
  assign op_is_div = 1'b0;
`endif

  assign res_hi    = (op_q == OP_MULHU) || (op_q == OP_REMU);
  assign iter_res  = res_hi ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
  assign last_step = (cnt_q == SHW'(WIDTH-1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    aluout_d    = aluout_q;
    zero_d      = zero_q;
    err_d       = err_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_MUL, ST_DIV: begin
        acc_d = iter_next;
        cnt_d = cnt_q + SHW'(1);
        if (last_step) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          aluout_d    = iter_res;
          zero_d      = (iter_res == '0);
          err_d       = 1'b0;
        end
      end
      default: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
        if (accept) begin
          op_d  = alucontrol;
          cnt_d = '0;
          if (op_is_mul) begin
            state_d = ST_MUL;
            acc_d   = {{WIDTH{1'b0}}, srcb};
            opnd_d  = srca;
          end else if (op_is_div) begin
            state_d = ST_DIV;
            acc_d   = {{WIDTH{1'b0}}, srca};
            opnd_d  = srcb;
          end else begin
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
            aluout_d    = sc_res;
            zero_d      = (sc_res == '0);
            err_d       = sc_err;
          end
        end
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      aluout_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      aluout_q    <= aluout_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=32): directed vector table, hand-written handshake/reset
// sequences, and random ops checked against an arithmetic reference model.
// DIVU/REMU expectations follow ALU_SEQ_DIV_EN.
module tb_alu_seq;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LONG_LAT = WIDTH + 1;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluout;
  logic        zero;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (alucontrol),
    .shamt      (shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .aluout     (aluout),
    .zero       (zero),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: run still active at time %0t, limit 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] res, input logic z, input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.res = res; v.z = z; v.e = e;
    tbl.push_back(v);
  endtask

  // Reference model: plain arithmetic on the opcode table.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic e,
                                  output int lat);
    logic [63:0] p;
    int          sa;
    int          sb;
    p   = {32'b0, a} * {32'b0, b};
    sa  = a;
    sb  = b;
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd3:  r = a ^ b;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd6:  r = sa >>> sh;
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  r = (a < b) ? 32'd1 : 32'd0;
      4'd9:  r = a - b;
      4'd10: begin r = p[31:0];  lat = LONG_LAT; end
      4'd11: begin r = p[63:32]; lat = LONG_LAT; end
`ifdef ALU_SEQ_DIV_EN
      4'd12: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = LONG_LAT; end
      4'd13: begin r = (b == 0) ? a : a % b;             lat = LONG_LAT; end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one op, wait for its result, optionally stall the consumer, then consume it.
  // Called and returns at 1 time unit after a rising edge.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input int stall,
                       input logic [31:0] xres, input logic xz, input logic xe, input int xlat);
    int lat;
    int guard;
    alucontrol = op; srca = a; srcb = b; shamt = sh; in_valid = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0; srca = $urandom; srcb = $urandom;
    shamt = 5'($urandom); alucontrol = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 2 * WIDTH) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, lat, xlat);
    chk({name, " aluout"}, aluout, xres);
    chk({name, " zero"}, zero, xz);
    chk({name, " err"}, err, xe);
    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      #1;
      chk({name, " in_ready under backpressure"}, in_ready, 1'b0);
      @(posedge clk); #1;
      chk({name, " held aluout"}, aluout, xres);
      chk({name, " held out_valid"}, out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, " consumed"}, out_valid, 1'b0);
  endtask

  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [4:0]  r_sh;
  logic [31:0] r_res;
  logic        r_e;
  int          r_lat;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    srca = '0; srcb = '0; alucontrol = '0; shamt = '0;

    // Vector table: hand-computed expected results.
    add_vec(4'b0010, 32'h0000_0234, 32'h0000_0EFF, 5'd0,  32'h0000_1133, 1'b0, 1'b0);
    add_vec(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
    add_vec(4'b1001, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
    add_vec(4'b1001, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1'b0);
    add_vec(4'b0001, 32'h1234_0000, 32'h0000_5678, 5'd0,  32'h1234_5678, 1'b0, 1'b0);
    add_vec(4'b0011, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd0,  32'h5A5A_A5A5, 1'b0, 1'b0);
    add_vec(4'b0100, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    add_vec(4'b0101, 32'h8000_0000, 32'h0000_0000, 5'd31, 32'h0000_0001, 1'b0, 1'b0);
    add_vec(4'b0110, 32'h8000_0000, 32'h0000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
    add_vec(4'b0110, 32'h7FFF_FFF0, 32'h0000_0000, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b0);
    add_vec(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
    add_vec(4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
    add_vec(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0);
    add_vec(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
    add_vec(4'b1010, 32'h1234_5678, 32'h0000_0010, 5'd0,  32'h2345_6780, 1'b0, 1'b0);
    add_vec(4'b1011, 32'h8000_0000, 32'h0000_0004, 5'd0,  32'h0000_0002, 1'b0, 1'b0);
    add_vec(4'b1111, 32'h1234_5678, 32'h1111_1111, 5'd3,  32'h0000_0000, 1'b1, 1'b1);
    add_vec(4'b1110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b1);
`ifdef ALU_SEQ_DIV_EN
    add_vec(4'b1100, 32'd100,        32'd7,         5'd0,  32'd14,         1'b0, 1'b0);
    add_vec(4'b1101, 32'd100,        32'd7,         5'd0,  32'd2,          1'b0, 1'b0);
    add_vec(4'b1100, 32'hDEAD_BEEF, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
    add_vec(4'b1101, 32'h0000_1234, 32'h0000_0000, 5'd0,  32'h0000_1234, 1'b0, 1'b0);
`else
    add_vec(4'b1100, 32'd100,        32'd7,         5'd0,  32'h0000_0000, 1'b1, 1'b1);
    add_vec(4'b1101, 32'h0000_1234, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1, 1'b1);
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset aluout", aluout, 32'h0);
    chk("reset zero", zero, 1'b0);
    chk("reset err", err, 1'b0);
    chk("reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Table-driven vectors.
    foreach (tbl[i]) begin
      ref_alu(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, r_res, r_e, r_lat);
      do_op($sformatf("vec%0d op%0h", i, tbl[i].op), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh,
            (i % 3 == 0) ? 2 : 0, tbl[i].res, tbl[i].z, tbl[i].e, r_lat);
    end

    // Back-to-back SUB then SRA at one op per cycle.
    in_valid = 1'b1; alucontrol = 4'b1001; srca = 32'd5; srcb = 32'd5; out_ready = 1'b1;
    #1 chk("b2b in_ready before SUB", in_ready, 1'b1);
    @(posedge clk); #1;
    alucontrol = 4'b0110; srca = 32'h8000_0000; shamt = 5'd4; srcb = $urandom;
    #1;
    chk("b2b SUB out_valid", out_valid, 1'b1);
    chk("b2b SUB aluout", aluout, 32'h0);
    chk("b2b SUB zero", zero, 1'b1);
    chk("b2b in_ready before SRA", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b SRA out_valid", out_valid, 1'b1);
    chk("b2b SRA aluout", aluout, 32'hF800_0000);
    chk("b2b SRA zero", zero, 1'b0);
    @(posedge clk); #1;
    chk("b2b drained", out_valid, 1'b0);

    // Output backpressure: ADD 1+1 held for 5 cycles while the next ADD waits.
    in_valid = 1'b1; alucontrol = 4'b0010; srca = 32'd1; srcb = 32'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    srca = 32'd3; srcb = 32'd4;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp hold aluout c%0d", i), aluout, 32'd2);
      chk($sformatf("bp hold out_valid c%0d", i), out_valid, 1'b1);
      chk($sformatf("bp in_ready low c%0d", i), in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("bp in_ready on release", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next op out_valid", out_valid, 1'b1);
    chk("bp next op aluout", aluout, 32'd7);
    @(posedge clk); #1;
    chk("bp drained", out_valid, 1'b0);

    // MULHU busy window: in_ready low, inputs offered meanwhile are ignored.
    in_valid = 1'b1; alucontrol = 4'b1011; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    alucontrol = 4'b1111; srca = 32'h5; srcb = 32'h5;
    begin
      int lat;
      lat = 1;
      while (!out_valid && lat < 2 * WIDTH) begin
        chk($sformatf("busy in_ready c%0d", lat), in_ready, 1'b0);
        if (lat == 6) in_valid = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
      chk("busy MULHU latency", lat, LONG_LAT);
    end
    chk("busy MULHU aluout", aluout, 32'hFFFF_FFFE);
    chk("busy MULHU err", err, 1'b0);
    @(posedge clk); #1;
    chk("busy no queued op", out_valid, 1'b0);

    // Asynchronous reset in the middle of a MUL.
    in_valid = 1'b1; alucontrol = 4'b1010; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midmul reset out_valid", out_valid, 1'b0);
    chk("midmul reset aluout", aluout, 32'h0);
    chk("midmul reset err", err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1 chk("midmul in_ready after release", in_ready, 1'b1);
    repeat (WIDTH + 2) @(posedge clk);
    #1 chk("midmul op discarded", out_valid, 1'b0);
    do_op("post-reset illegal", 4'b1111, 32'hABCD_0123, 32'h1, 5'd0, 0, 32'h0, 1'b1, 1'b1, 1);

    // Randomised ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = '0;
        1:       r_b = 32'($urandom_range(1, 20));
        default: r_b = r_b;
      endcase
      if ($urandom_range(0, 3) == 0) r_a = 32'($urandom_range(0, 1000));
      r_sh = 5'($urandom);
      ref_alu(r_op, r_a, r_b, r_sh, r_res, r_e, r_lat);
      do_op($sformatf("rnd%0d op%0h", i, r_op), r_op, r_a, r_b, r_sh,
            int'($urandom_range(0, 2)), r_res, (r_res == 32'h0), r_e, r_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
